// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared encodings and helpers for the E-stage multiply/divide unit
//
// Contents:
//   mdu_op_e       4-bit MDU operation encoding driven by the controller decode
//   mdu_state_e    sequencer state (IDLE / BUSY)
//   default busy-cycle counts for multiply and divide
//   is_arith/is_mult/is_div  operation classification helpers
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEFAULT  = 10;

  // Operations that start a busy period.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit and HI/LO owner for the E stage
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   E_MDUOp   in   4   operation (mdu_op_e encoding)
//   Start     in   1   E-stage MULT/MULTU/DIV/DIVU issue this cycle
//   Req       in   1   exception/interrupt flush; blocks state changes requested this cycle
//   A, B      in   32  forwarded rs / rt operands
//   Busy      out  1   computation in progress
//   E_MDUOut  out  32  HI on MFHI, LO on MFLO, else 0 (combinational)
//   HI, LO    out  32  current HI / LO registers
//
// The arithmetic itself is plain operators on the latched operands; the
// countdown only models latency, and the result is captured on the edge
// where the counter reaches 1.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        Start,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] E_MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;

  // Products: the low 64 bits of a 64x64 product of sign-extended operands
  // equal the signed 32x32 product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
  end

  // Division. The divisor is forced to 1 when zero so the operators never
  // see a zero divisor; the result is discarded in that case anyway.
  logic        div_zero;
  logic [31:0] divu_den;
  logic [31:0] divu_q;
  logic [31:0] divu_r;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divs_qm;
  logic [31:0] divs_rm;
  logic [31:0] divs_q;
  logic [31:0] divs_r;

  always_comb begin
    div_zero = (b_q == 32'd0);
    divu_den = div_zero ? 32'd1 : b_q;
    divu_q   = a_q / divu_den;
    divu_r   = a_q % divu_den;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // magnitude 0x80000000 with positive sign, i.e. 0x80000000, remainder 0.
    a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
    if (div_zero) begin
      b_mag = 32'd1;
    end
    divs_qm  = a_mag / b_mag;
    divs_rm  = a_mag % b_mag;
    divs_q   = (a_q[31] ^ b_q[31]) ? (~divs_qm + 32'd1) : divs_qm;
    divs_r   = a_q[31] ? (~divs_rm + 32'd1) : divs_rm;
  end

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b1;
    case (op_q)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res_hi = divs_r;
        res_lo = divs_q;
        res_we = !div_zero;
      end
      MDU_DIVU: begin
        res_hi = divu_r;
        res_lo = divu_q;
        res_we = !div_zero;
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MDU_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A flushed E-stage instruction must leave no trace.
          if (!Req) begin
            if (Start && is_arith(E_MDUOp)) begin
              op_q    <= E_MDUOp;
              a_q     <= A;
              b_q     <= B;
              cnt_q   <= is_mult(E_MDUOp) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
              state_q <= ST_BUSY;
              busy_q  <= 1'b1;
            end else if (E_MDUOp == MDU_MTHI) begin
              hi_q <= A;
            end else if (E_MDUOp == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_BUSY: begin
          // Req is deliberately ignored here: the running operation belongs
          // to an older instruction and must complete.
          if (cnt_q == 4'd1) begin
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            cnt_q   <= 4'd0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (E_MDUOp)
      MDU_MFHI: E_MDUOut = hi_q;
      MDU_MFLO: E_MDUOut = lo_q;
      default:  E_MDUOut = 32'd0;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu with a behavioural HI/LO model
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op;
  logic        start;
  logic        req;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  // Reference state of the architectural registers.
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .E_MDUOp  (op),
    .Start    (start),
    .Req      (req),
    .A        (a),
    .B        (b),
    .Busy     (busy),
    .E_MDUOut (mdu_out),
    .HI       (hi),
    .LO       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of an MD operation, from the arithmetic rules.
  task automatic model_apply(input logic [3:0] mop, input logic [31:0] x, input logic [31:0] y);
    longint          sx;
    longint          sy;
    longint          q;
    longint          r;
    longint unsigned p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (mop)
      MDU_MULT: begin
        p = longint'(sx * sy);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MDU_MULTU: begin
        p = longint'({32'd0, x}) * longint'({32'd0, y});
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MDU_DIV: begin
        if (y != 32'd0) begin
          q = sx / sy;
          r = sx % sy;
          lo_m = q[31:0];
          hi_m = r[31:0];
        end
      end
      MDU_DIVU: begin
        if (y != 32'd0) begin
          lo_m = x / y;
          hi_m = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one MD operation and follow it to completion.
  // mid: 0 = quiet, 1 = Req held during BUSY, 2 = MTHI forced during BUSY.
  task automatic run_op(input string tag, input logic [3:0] mop,
                        input logic [31:0] x, input logic [31:0] y, input int mid);
    int          n;
    int unsigned want;
    logic [31:0] hi_old;
    want   = is_mult(mop) ? MC : DC;
    hi_old = hi_m;
    @(negedge clk);
    op = mop; start = 1'b1; req = 1'b0; a = x; b = y;
    @(negedge clk);
    op = MDU_NONE; start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      a   = $urandom;
      b   = $urandom;
      req = (mid == 1);
      op  = (mid == 2) ? 4'(MDU_MTHI) : 4'(MDU_NONE);
      if (mid == 2) check({tag, " hi_held"}, hi, hi_old);
      @(negedge clk);
    end
    op = MDU_NONE; req = 1'b0;
    check({tag, " busy_cycles"}, 32'(n), 32'(want));
    model_apply(mop, x, y);
    check({tag, " hi"}, hi, hi_m);
    check({tag, " lo"}, lo, lo_m);
    op = MDU_MFHI;
    #1 check({tag, " mfhi"}, mdu_out, hi_m);
    op = MDU_MFLO;
    #1 check({tag, " mflo"}, mdu_out, lo_m);
    op = MDU_NONE;
  endtask

  task automatic move_to(input string tag, input logic [3:0] mop, input logic [31:0] x);
    @(negedge clk);
    op = mop; start = 1'b0; req = 1'b0; a = x;
    @(negedge clk);
    op = MDU_NONE;
    if (mop == MDU_MTHI) hi_m = x;
    else lo_m = x;
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " hi"}, hi, hi_m);
    check({tag, " lo"}, lo, lo_m);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; op = MDU_NONE; start = 1'b0; req = 1'b0; a = '0; b = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset out", mdu_out, 32'd0);
    rst_n = 1'b1;

    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("divu_17_5", MDU_DIVU, 32'd17, 32'd5, 0);
    run_op("div_m17_5", MDU_DIV, 32'hFFFF_FFEF, 32'd5, 0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    move_to("mthi_11", MDU_MTHI, 32'h11);
    move_to("mtlo_22", MDU_MTLO, 32'h22);
    run_op("div_zero", MDU_DIV, 32'd1234, 32'd0, 0);
    run_op("divu_zero", MDU_DIVU, 32'hFFFF_FFFF, 32'd0, 0);

    // Flushed issue: nothing may change.
    @(negedge clk);
    op = MDU_MULTU; start = 1'b1; req = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    op = MDU_NONE; start = 1'b0; req = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush hi", hi, hi_m);
    check("flush lo", lo, lo_m);
    @(negedge clk);
    check("flush busy2", 32'(busy), 32'd0);

    // Flushed MTHI is suppressed as well.
    op = MDU_MTHI; req = 1'b1; a = 32'hA5A5_A5A5;
    @(negedge clk);
    op = MDU_NONE; req = 1'b0;
    check("flush mthi", hi, hi_m);

    run_op("mult_req_mid", MDU_MULT, 32'h1234_5678, 32'h8765_4321, 1);
    move_to("mtlo_dead", MDU_MTLO, 32'hDEAD_BEEF);
    run_op("divu_mthi_mid", MDU_DIVU, 32'hDEAD_BEEF, 32'd7, 2);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    op = MDU_DIV; start = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    op = MDU_NONE; start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check("arst busy", 32'(busy), 32'd0);
    check("arst hi", hi, 32'd0);
    check("arst lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst busy_after", 32'(busy), 32'd0);
    run_op("mult_6_7", MDU_MULT, 32'd6, 32'd7, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9)) ^ ({32{rb[31]}});
      run_op($sformatf("rand%0d", i), rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit and its sequencer for the E stage of the P7 pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E stage and owns the HI/LO registers.
- Runs a fixed-latency busy countdown, and exports Start/Busy so hazard logic can stall MD instructions in D.
- Suppresses issue when the E-stage instruction is flushed by an exception or interrupt.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- E_MDUOp  input  4  operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
- Start  input  1  E-stage instruction is a MULT/MULTU/DIV/DIVU issue this cycle
- Req  input  1  exception/interrupt flush of the E-stage instruction; blocks all state changes requested this cycle
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Busy  output  1  computation in progress
- E_MDUOut  output  32  HI when MFHI, LO when MFLO, else 0 (combinational)
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- Reset (reset low, async): HI=0, LO=0, Busy=0, counter=0, state IDLE, operand/op latches=0.
- States:
  - IDLE: Busy=0.
  - BUSY: Busy=1, counter counts down.
- IDLE -> BUSY at edge k when Start=1, Req=0 and E_MDUOp is MULT/MULTU/DIV/DIVU:
  - latch A, B, op;
  - counter := MULT_CYCLES or DIV_CYCLES.
- Start=1 with a non-arithmetic E_MDUOp is ignored.
- In BUSY, each edge decrements the counter. At the edge where counter==1:
  - write HI/LO from the latched operands;
  - counter := 0 and state := IDLE.
- Timing: Busy is high in cycles k+1..k+N. New HI/LO are visible in cycle k+N+1. Busy=0 in that same cycle.
- Arithmetic rules:
  - MULT: signed 32x32->64; HI = upper word, LO = lower word.
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero: still runs the full DIV_CYCLES busy period; HI/LO left unchanged.
- MTHI/MTLO, when Req=0 and in IDLE: HI (resp. LO) := A at the edge; no busy period.
- Blocked requests: MTHI/MTLO/Start while BUSY are ignored. Hazard logic guarantees they cannot occur; the block must still not corrupt state.
- Req=1:
  - Start and MTHI/MTLO in the same cycle are suppressed; no state change.
  - An operation already in BUSY is not cancelled and completes normally (precise-exception rule: it was issued by an earlier instruction).
- Latched operands are used, so A/B changes during BUSY have no effect.
- MFHI/MFLO read the current registers combinationally.
- Reset asserted mid-operation: immediate return to the reset values; the partial result is discarded.
- Hazard contract (implemented outside this block): a D-stage MD instruction stalls while (Start | Busy).

Decomposition:
- constants.v gains:
  - MDU_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO 4-bit encodings;
  - default cycle counts.
- The opcode-to-MDUOp decode stays in the controller.
- No sub-module. Multiply and divide use synthesizable operators on the latched operands, registered at completion; the countdown models latency.

Test Plan:
- MULT A=0xFFFFFFFE, B=3, Req=0 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI returns 0xFFFFFFFF the cycle after Busy falls.
- DIVU A=17, B=5 -> Busy high 10 cycles; LO=3, HI=2. DIV A=-17 (0xFFFFFFEF), B=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE.
- DIV by zero with HI=0x11, LO=0x22 preset via MTHI/MTLO -> Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Start=1 with MULTU and Req=1 in the same cycle -> Busy stays 0, HI/LO unchanged. Req=1 asserted mid-BUSY -> operation still completes with the correct result.
- MTLO A=0xDEADBEEF with Req=0 -> LO=0xDEADBEEF next cycle, Busy never rises. MTHI during BUSY (forced by the bench) -> HI unchanged until the operation result is written.
- Assert reset low at cycle 3 of a DIV -> Busy=0, HI=LO=0 immediately (async). After release, a new MULT 6x7 gives LO=42 after 5 cycles.
